// File: rtl/sumador_acumulador_pkg.sv
// sumador_acumulador_pkg: FSM encoding, symmetric saturation bounds and counter width
// shared by the accumulator and its saturating adder.
package sumador_acumulador_pkg;
    typedef enum logic [1:0] {IDLE, ACUM, SALIDA} estado_t;
    localparam int CuentaW = 8;
    function automatic int maximo(input int w);
        return (1 << (w - 1)) - 1;
    endfunction
    // Symmetric range: the most negative code is never produced.
    function automatic int minimo(input int w);
        return -maximo(w);
    endfunction
endpackage

// File: rtl/sumador_acumulador_saturado.sv
// sumador_saturado: one-guard-bit signed add clamped to the symmetric range,
// flagging any clip on o_sat.
module sumador_saturado
    import sumador_acumulador_pkg::*;
#(
    parameter int Width = 7
) (
    input  logic signed [Width-1:0] i_a,
    input  logic signed [Width-1:0] i_b,
    output logic signed [Width-1:0] o_suma,
    output logic                    o_sat
);
    localparam logic signed [Width:0] MaxExt = (Width + 1)'(maximo(Width));
    localparam logic signed [Width:0] MinExt = (Width + 1)'(minimo(Width));
    logic signed [Width:0] w_ext;
    logic                  w_alto;
    logic                  w_bajo;
    always_comb begin
        w_ext  = {i_a[Width-1], i_a} + {i_b[Width-1], i_b};
        w_alto = w_ext > MaxExt;
        w_bajo = w_ext < MinExt;
        o_sat  = w_alto | w_bajo;
        o_suma = w_alto ? MaxExt[Width-1:0] : w_bajo ? MinExt[Width-1:0] : w_ext[Width-1:0];
    end
endmodule

// File: rtl/sumador_acumulador.sv
// sumador_acumulador: sums Taps saturated products with per-step clamping and
// presents the result for one cycle with a sticky saturation flag.
module sumador_acumulador
    import sumador_acumulador_pkg::*;
#(
    parameter int Width     = 7,
    parameter int Presicion = 0,
    parameter int Taps      = 4
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic signed [Width-1:0] Producto,
    input  logic                    Producto_Valido,
    output logic                    Listo,
    output logic signed [Width-1:0] Suma,
    output logic                    Suma_Valida,
    output logic                    Saturado
);
    if (Taps < 1 || Taps > 255) begin : g_taps_err
        $error("sumador_acumulador: Taps must be in 1..255");
    end
    if (Presicion < 0 || Presicion >= Width) begin : g_prec_err
        $error("sumador_acumulador: Presicion must be in 0..Width-1");
    end

    localparam logic [CuentaW-1:0] TapsC = CuentaW'(Taps);

    estado_t                 r_estado;
    estado_t                 w_sig;
    logic signed [Width-1:0] r_acum;
    logic signed [Width-1:0] r_suma;
    logic signed [Width-1:0] w_b;
    logic signed [Width-1:0] w_res;
    logic [CuentaW-1:0]      r_cuenta;
    logic [CuentaW-1:0]      w_cuenta;
    logic                    r_sticky;
    logic                    r_sat;
    logic                    w_sat;
    logic                    w_sticky;
    logic                    w_acepta;
    logic                    w_ultimo;

    assign Listo       = r_estado != SALIDA;
    assign Suma_Valida = r_estado == SALIDA;
    assign Suma        = r_suma;
    assign Saturado    = r_sat;

    // Adding zero in IDLE lets the single adder also clamp a first product of -2^(Width-1).
    sumador_saturado #(.Width(Width)) u_sumador (
        .i_a   (Producto),
        .i_b   (w_b),
        .o_suma(w_res),
        .o_sat (w_sat)
    );

    always_comb begin
        w_acepta = Producto_Valido && Listo;
        w_b      = (r_estado == IDLE) ? '0 : r_acum;
        w_cuenta = (r_estado == IDLE) ? CuentaW'(1) : r_cuenta + 1'b1;
        w_sticky = ((r_estado == IDLE) ? 1'b0 : r_sticky) | w_sat;
        w_ultimo = w_acepta && (w_cuenta == TapsC);
        w_sig    = (r_estado == SALIDA) ? IDLE : w_ultimo ? SALIDA : w_acepta ? ACUM : r_estado;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_estado <= IDLE;
            r_acum   <= '0;
            r_cuenta <= '0;
            r_sticky <= 1'b0;
            r_suma   <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_estado <= w_sig;
            if (w_acepta) begin
                r_acum   <= w_res;
                r_cuenta <= w_cuenta;
                r_sticky <= w_sticky;
            end
            if (w_ultimo) begin
                r_suma <= w_res;
                r_sat  <= w_sticky;
            end
        end
    end
endmodule

// File: tb/tb_sumador_acumulador.sv
// tb_sumador_acumulador: directed vectors with a queued scoreboard per instance
// (Taps=4 and Taps=1); monitors pop expectations on every Suma_Valida pulse.
module tb_sumador_acumulador;
    typedef struct {
        int suma;
        bit sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [6:0] prod4 = '0;
    logic              vld4 = 1'b0;
    logic              listo4;
    logic signed [6:0] suma4;
    logic              sv4;
    logic              sat4;
    logic signed [6:0] prod1 = '0;
    logic              vld1 = 1'b0;
    logic              listo1;
    logic signed [6:0] suma1;
    logic              sv1;
    logic              sat1;

    exp_t q4[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last1 = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sumador_acumulador #(.Width(7), .Presicion(0), .Taps(4)) dut4 (
        .CLK(clk), .RESET_N(rst_n), .Producto(prod4), .Producto_Valido(vld4),
        .Listo(listo4), .Suma(suma4), .Suma_Valida(sv4), .Saturado(sat4)
    );

    sumador_acumulador #(.Width(7), .Presicion(0), .Taps(1)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .Producto(prod1), .Producto_Valido(vld1),
        .Listo(listo1), .Suma(suma1), .Suma_Valida(sv1), .Saturado(sat1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && sv4) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse4: got unexpected pulse Suma=%0d expected none", suma4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("suma4", int'(suma4), e.suma);
                chk("sat4", int'(sat4), int'(e.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && sv1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse1: got unexpected pulse Suma=%0d expected none", suma1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("suma1", int'(suma1), e.suma);
                chk("sat1", int'(sat1), int'(e.sat));
            end
            if (last1 >= 0) chk("spacing1", cyc - last1, 2);
            last1 = cyc;
        end
    end

    task automatic put(input int p, input bit v);
        @(negedge clk);
        prod4 = 7'(p);
        vld4  = v;
    endtask

    // Feeds four products back to back, then checks the pulse in the following cycle.
    task automatic feed(input int a, input int b, input int c, input int d,
                        input int es, input bit esat, input bit ruido);
        q4.push_back('{es, esat});
        put(a, 1);
        put(b, 1);
        put(c, 1);
        put(d, 1);
        put(50, ruido);
        chk("latency_valid", int'(sv4), 1);
        chk("listo_salida", int'(listo4), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_suma", int'(suma4), 0);
        chk("rst_valid", int'(sv4), 0);
        chk("rst_sat", int'(sat4), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_listo", int'(listo4), 1);

        feed(1, 2, 3, 4, 10, 1'b0, 1'b0);
        put(0, 0);
        put(0, 0);
        put(0, 0);
        chk("hold_suma", int'(suma4), 10);
        chk("hold_valid", int'(sv4), 0);

        feed(40, 40, 40, 40, 63, 1'b1, 1'b0);
        feed(-40, -40, -40, -40, -63, 1'b1, 1'b0);
        feed(60, 10, -20, 5, 48, 1'b1, 1'b1);

        q4.push_back('{11, 1'b0});
        put(5, 1);
        put(0, 0);
        put(0, 0);
        put(0, 0);
        put(-2, 1);
        put(7, 1);
        put(1, 1);
        put(0, 0);
        put(0, 0);

        put(1, 1);
        put(2, 1);
        @(negedge clk);
        rst_n = 1'b0;
        vld4  = 1'b0;
        @(negedge clk);
        chk("abort_suma", int'(suma4), 0);
        chk("abort_listo", int'(listo4), 1);
        rst_n = 1'b1;
        feed(1, 1, 1, 1, 4, 1'b0, 1'b0);
        put(0, 0);

        for (int i = 0; i < 4; i++) q1.push_back('{-63, 1'b1});
        @(negedge clk);
        prod1 = -7'sd64;
        vld1  = 1'b1;
        repeat (8) @(negedge clk);
        vld1 = 1'b0;

        for (int i = 0; i < 20 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        while (q4.size() != 0) begin
            exp_t e;
            e = q4.pop_front();
            chk("missing4", 0, e.suma);
        end
        while (q1.size() != 0) begin
            exp_t e;
            e = q1.pop_front();
            chk("missing1", 0, e.suma);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
